dlx_fetch_unit: RTL and testbench
=================================

# dlx_fetch_unit

Instruction-fetch stage for the DLX pipeline, and the consumer of the decode-stage jump/branch resolver's redirect (`take_branch`, `branch_target`). It owns the program counter, issues requests to instruction memory over a request/acknowledge handshake, and loads the IF/ID register with the fetched instruction and its PC+4. On a redirect it squashes the wrong-path instruction and refetches from the target. It also absorbs decode stalls with a one-entry skid buffer.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_req`  out  1: fetch request valid.
- `imem_addr`  out  32: word-aligned fetch address; bits [1:0] always 0.
- `imem_ack`  in  1: memory returns data this cycle for the outstanding request.
- `imem_rdata`  in  32: instruction word, valid when `imem_ack`=1.
- `stall`  in  1: decode cannot accept; IF/ID must hold.
- `take_branch`  in  1: redirect from the jump/branch resolver for the instruction in IF/ID.
- `branch_target`  in  32: redirect PC, valid with `take_branch`.
- `ifid_valid`  out  1: IF/ID holds a live instruction.
- `ifid_instr`  out  32: IF/ID instruction word.
- `ifid_pc_plus_four`  out  32: PC+4 of `ifid_instr`; feeds the branch resolver and the `jal` link value.

## Operation
- `pc` register; `imem_addr` = {`pc`[31:2], 2'b00}. PC+4 is mod 2^32, so 32'hFFFF_FFFC wraps to 0.
- FSM states:
  - FETCH: `imem_req`=1.
  - HOLD: skid buffer full; `imem_req`=0.
  - DISCARD: a redirect arrived with a request outstanding and unacked. `imem_req` stays 1 at the old address until ack; the returned data is dropped.
- Handshake: once raised, `imem_req` and `imem_addr` stay stable until the cycle `imem_ack`=1. Ack is allowed in the same cycle as the request.
- `take_branch` is honoured only when `stall`=0; while stalled it is ignored.
- FETCH, ack, no stall, no redirect: IF/ID <= {1, `imem_rdata`, `pc`+4}; `pc` <= `pc`+4; stay in FETCH.
- FETCH, ack, `stall`=1: data and `pc`+4 go to the skid buffer; `pc` <= `pc`+4; go to HOLD; IF/ID unchanged.
- HOLD, `stall`=0, no redirect: skid moves to IF/ID; go to FETCH.
- Redirect (`take_branch`=1, `stall`=0) from any state:
  - `ifid_valid` <= 0.
  - Skid buffer is cleared.
  - `pc` <= `branch_target`.
- Redirect state after the redirect:
  - Ack in the same cycle: the acked data is dropped and the next state is FETCH.
  - Request outstanding and unacked: go to DISCARD.
  - From HOLD: go to FETCH.
- DISCARD, ack: drop data; go to FETCH at the already-updated `pc`.
- DISCARD, another redirect: `pc` <= new target; stay in DISCARD.
- `stall`=0, no ack, no redirect, in FETCH: `ifid_valid` <= 0 (a bubble is inserted).
- `stall`=1: IF/ID holds all fields.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - `pc`=`RESET_PC`; state FETCH.
  - `imem_req`=0.
  - `ifid_valid`=0, `ifid_instr`=32'h0, `ifid_pc_plus_four`=32'h0.
  - Skid buffer empty.
- `imem_req` rises in the first cycle after `rst_n` deasserts.
- Reset mid-transaction abandons any outstanding request; memory must tolerate this.
- Throughput: one instruction per cycle when ack is always same-cycle.
- Fetch latency: ack sampled at edge E puts the instruction in IF/ID after E.
- Redirect sampled at edge E:
  - `imem_addr` = target in the cycle after E.
  - Target instruction reaches IF/ID at least one edge later.
  - Penalty is one bubble, plus one cycle per extra ack-wait cycle spent in DISCARD.
- The skid buffer guarantees no fetched instruction is lost or duplicated across a stall.

## Structure
- Package `dlx_fetch_pkg`:
  - FSM state enum `fetch_state_t` (FETCH, HOLD, DISCARD).
  - `DLX_NOP` = 32'h0.
  - `DLX_RESET_PC_DEFAULT`.
- Sub-module `fetch_skid_buffer`: one-entry {instr, pc_plus_four} register with load, drain and clear controls.

## Test plan
- Reset release, `RESET_PC`=32'h100, ack every cycle -> addresses 100, 104, 108; IF/ID shows `ifid_pc_plus_four` 104, 108, 10C with valid=1.
- `take_branch`=1, target 32'h200, with a same-cycle ack at 32'h10C -> 10C data never appears in IF/ID; next cycle `ifid_valid`=0 and `imem_addr`=200.
- Redirect to 32'h300 while the 0x110 request waits 3 cycles for ack -> `imem_addr` holds 110 until ack, that data is dropped, then `imem_addr`=300.
- Ack with data 32'hDEAD_BEEF during `stall`=1 for 4 cycles -> IF/ID unchanged and `imem_req`=0 while held; on release IF/ID gets DEADBEEF; no gap, no duplicate.
- `pc`=32'hFFFF_FFFC fetched -> `ifid_pc_plus_four`=0, next `imem_addr`=0.
- Assert `rst_n`=0 mid-DISCARD -> all outputs return to reset values immediately; first request after release is at `RESET_PC`.

Source files
------------

// File: rtl/dlx_fetch_pkg.sv
// Shared types and constants for the DLX instruction-fetch stage.
package dlx_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DLX_NOP              = 32'h0000_0000;
  localparam logic [31:0] DLX_RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc_plus_four} holding register that absorbs a fetch landing during a stall.
module fetch_skid_buffer
  import dlx_fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus_four_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus_four_o
);

  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_plus_four_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q        <= 1'b0;
      instr_q        <= DLX_NOP;
      pc_plus_four_q <= 32'h0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q        <= 1'b1;
      instr_q        <= instr_i;
      pc_plus_four_q <= pc_plus_four_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o        = valid_q;
  assign instr_o        = instr_q;
  assign pc_plus_four_o = pc_plus_four_q;

endmodule

// File: rtl/dlx_fetch_unit.sv
// DLX instruction-fetch stage: PC, imem request/ack handshake, IF/ID register, redirect squash
// and a one-entry skid buffer for decode stalls.
module dlx_fetch_unit
  import dlx_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DLX_RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        take_branch,
  input  logic [31:0] branch_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus_four
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  disc_addr_q, disc_addr_d;
  logic         req_en_q;
  logic         ifid_valid_q, ifid_valid_d;
  logic [31:0]  ifid_instr_q, ifid_instr_d;
  logic [31:0]  ifid_pc4_q, ifid_pc4_d;

  logic         ack;
  logic         redirect;
  logic [31:0]  fetch_addr;
  logic [31:0]  fetch_pc4;
  logic         skid_load, skid_drain, skid_clear;
  logic         skid_valid;
  logic [31:0]  skid_instr, skid_pc4;

  assign fetch_addr = word_align(pc_q);
  assign fetch_pc4  = fetch_addr + 32'd4;
  assign ack        = imem_ack & imem_req;
  assign redirect   = take_branch & ~stall;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          state_d = (imem_req && !imem_ack) ? DISCARD : FETCH;
        end else if (ack && stall) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect || !stall) state_d = FETCH;
      end
      DISCARD: begin
        if (ack) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Memory-side outputs; DISCARD keeps presenting the abandoned address until it is acked
  always_comb begin
    imem_req  = req_en_q && (state_q != HOLD);
    imem_addr = (state_q == DISCARD) ? disc_addr_q : fetch_addr;
  end

  // Datapath next-state
  always_comb begin
    pc_d         = pc_q;
    disc_addr_d  = disc_addr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    skid_load    = 1'b0;
    skid_drain   = 1'b0;
    skid_clear   = 1'b0;
    if (redirect) begin
      pc_d         = branch_target;
      ifid_valid_d = 1'b0;
      skid_clear   = 1'b1;
      if (state_q == FETCH) disc_addr_d = fetch_addr;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ack) begin
            pc_d = fetch_pc4;
            if (stall) begin
              skid_load = 1'b1;
            end else begin
              ifid_valid_d = 1'b1;
              ifid_instr_d = imem_rdata;
              ifid_pc4_d   = fetch_pc4;
            end
          end else if (!stall) begin
            ifid_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_valid_d = skid_valid;
            ifid_instr_d = skid_instr;
            ifid_pc4_d   = skid_pc4;
            skid_drain   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      disc_addr_q  <= 32'h0;
      req_en_q     <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= DLX_NOP;
      ifid_pc4_q   <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      disc_addr_q  <= disc_addr_d;
      req_en_q     <= 1'b1;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  fetch_skid_buffer u_skid (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .load_i         (skid_load),
    .drain_i        (skid_drain),
    .clear_i        (skid_clear),
    .instr_i        (imem_rdata),
    .pc_plus_four_i (fetch_pc4),
    .valid_o        (skid_valid),
    .instr_o        (skid_instr),
    .pc_plus_four_o (skid_pc4)
  );

  assign ifid_valid        = ifid_valid_q;
  assign ifid_instr        = ifid_instr_q;
  assign ifid_pc_plus_four = ifid_pc4_q;

endmodule

// File: tb/tb_dlx_fetch_unit.sv
// Bench for dlx_fetch_unit: directed scenarios then random stall/ack/redirect traffic, checked
// against the architectural instruction stream the fetch stage must deliver.
module tb_dlx_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        take_branch = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus_four;

  int          n_assert = 0;
  int          n_fail = 0;
  int          deliveries = 0;
  logic [31:0] exp_pc;

  dlx_fetch_unit #(
    .RESET_PC (32'h0000_0100)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ack          (imem_ack),
    .imem_rdata        (imem_rdata),
    .stall             (stall),
    .take_branch       (take_branch),
    .branch_target     (branch_target),
    .ifid_valid        (ifid_valid),
    .ifid_instr        (ifid_instr),
    .ifid_pc_plus_four (ifid_pc_plus_four)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Program memory contents as a pure function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0304) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after a falling edge, then check what the next falling edge shows.
  task automatic step(input bit st, input bit br, input logic [31:0] tgt, input bit ack_en);
    logic        ack, pend, redir, redir_clean, pv;
    logic [31:0] pend_addr, pi, pp;
    ack           = ack_en && imem_req;
    stall         = st;
    take_branch   = br;
    branch_target = tgt;
    imem_ack      = ack;
    imem_rdata    = ack ? mem_word(imem_addr) : $urandom();
    pend          = imem_req && !ack;
    pend_addr     = imem_addr;
    redir         = br && !st;
    redir_clean   = redir && (!imem_req || ack);
    pv            = ifid_valid;
    pi            = ifid_instr;
    pp            = ifid_pc_plus_four;
    if (redir) exp_pc = tgt;
    @(posedge clk);
    @(negedge clk);
    if (st) begin
      check("hold_valid", 32'(ifid_valid), 32'(pv));
      check("hold_instr", ifid_instr, pi);
      check("hold_pc4", ifid_pc_plus_four, pp);
    end else if (redir) begin
      check("squash_valid", 32'(ifid_valid), 32'h0);
    end else if (ifid_valid) begin
      check("seq_pc4", ifid_pc_plus_four, exp_pc + 32'd4);
      check("seq_instr", ifid_instr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      deliveries++;
    end
    if (pend) begin
      check("req_stable", 32'(imem_req), 32'h1);
      check("addr_stable", imem_addr, pend_addr);
    end
    if (redir_clean) begin
      check("redir_addr", imem_addr, tgt);
      check("redir_req", 32'(imem_req), 32'h1);
    end
    check("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
  endtask

  initial begin
    logic [31:0] r;
    exp_pc = 32'h100;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_valid", 32'(ifid_valid), 32'h0);
    check("rst_instr", ifid_instr, 32'h0);
    check("rst_pc4", ifid_pc_plus_four, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'h1);
    check("first_addr", imem_addr, 32'h100);

    // Back-to-back same-cycle acks
    step(0, 0, 0, 1);
    check("tp_pc4_0", ifid_pc_plus_four, 32'h104);
    check("tp_addr_1", imem_addr, 32'h104);
    step(0, 0, 0, 1);
    check("tp_pc4_1", ifid_pc_plus_four, 32'h108);
    step(0, 0, 0, 1);
    check("tp_pc4_2", ifid_pc_plus_four, 32'h10C);
    check("tp_valid", 32'(ifid_valid), 32'h1);
    check("tp_addr_3", imem_addr, 32'h10C);

    // Redirect with same-cycle ack, then redirect with a slow outstanding request
    step(0, 1, 32'h200, 1);
    step(0, 1, 32'h110, 1);
    check("at_110", imem_addr, 32'h110);
    step(0, 1, 32'h300, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("disc_done_addr", imem_addr, 32'h300);
    check("disc_drop_valid", 32'(ifid_valid), 32'h0);

    // Ack during a four-cycle stall lands in the skid buffer
    step(0, 0, 0, 1);
    check("pre_stall_valid", 32'(ifid_valid), 32'h1);
    check("pre_stall_pc4", ifid_pc_plus_four, 32'h304);
    step(1, 0, 0, 1);
    check("hold_req_0", 32'(imem_req), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      check("hold_req", 32'(imem_req), 32'h0);
    end
    step(0, 0, 0, 0);
    check("skid_instr", ifid_instr, 32'hDEAD_BEEF);
    check("skid_pc4", ifid_pc_plus_four, 32'h308);
    check("post_skid_addr", imem_addr, 32'h308);
    step(0, 0, 0, 1);
    check("post_skid_seq", ifid_pc_plus_four, 32'h30C);

    // PC wrap
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1);
    check("wrap_pc4", ifid_pc_plus_four, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset in the middle of DISCARD
    step(0, 1, 32'h500, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(imem_req), 32'h0);
    check("mid_rst_valid", 32'(ifid_valid), 32'h0);
    check("mid_rst_instr", ifid_instr, 32'h0);
    check("mid_rst_pc4", ifid_pc_plus_four, 32'h0);
    check("mid_rst_addr", imem_addr, 32'h100);
    stall = 1'b0; take_branch = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 32'h100;
    @(negedge clk);
    check("rerst_req", 32'(imem_req), 32'h1);
    check("rerst_addr", imem_addr, 32'h100);
    step(0, 0, 0, 1);
    check("rerst_pc4", ifid_pc_plus_four, 32'h104);

    // Random traffic
    deliveries = 0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom();
      if (($urandom() % 4) == 0) r = 32'hFFFF_FFF4;
      step(($urandom() % 4) == 0, ($urandom() % 10) == 0, {r[31:2], 2'b00},
           ($urandom() % 3) != 0);
    end
    check("random_live", 32'(deliveries > 500), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
